sprite_merge_n: RTL and testbench

SPRITE_MERGE_N -- requirements
Module: sprite_merge_n

---
 rtl/sprite_merge_n.sv | 131 +++++++++++++
 tb/tb_sprite_merge_n.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_merge_n.sv
// Sprite merge: picks the lowest-index opaque sprite over the background per pixel.
// Latency 2 cycles, no backpressure (one pixel per cycle); optional SPRITE_MERGE_COLL_EN adds sticky collision flags.
module sprite_merge_n #(
    parameter int NUM_SP = 4,
    parameter int CW     = 8,
    parameter int PW     = 10,
    parameter int SP_W   = 16,
    parameter int SP_H   = 16,
    parameter int KEY    = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pix_valid,
    input  logic [PW-1:0]        pix_x,
    input  logic [PW-1:0]        pix_y,
    input  logic [CW-1:0]        R_bg,
    input  logic [CW-1:0]        G_bg,
    input  logic [CW-1:0]        B_bg,
    input  logic [NUM_SP*CW-1:0] R_sp,
    input  logic [NUM_SP*CW-1:0] G_sp,
    input  logic [NUM_SP*CW-1:0] B_sp,
    input  logic [NUM_SP*PW-1:0] posX_sp,
    input  logic [NUM_SP*PW-1:0] posY_sp,
    input  logic [NUM_SP-1:0]    sp_en,
    input  logic                 clr_coll,
    output logic [CW-1:0]        R_out,
    output logic [CW-1:0]        G_out,
    output logic [CW-1:0]        B_out,
    output logic                 out_valid,
    output logic [NUM_SP-1:0]    collision
);

    localparam logic [PW:0]   L_SPW = (PW+1)'(SP_W);
    localparam logic [PW:0]   L_SPH = (PW+1)'(SP_H);
    localparam logic [CW-1:0] L_KEY = CW'(KEY);

    logic [NUM_SP-1:0]    w_opq;
    logic [NUM_SP-1:0]    r_opq;
    logic                 r_v1;
    logic [NUM_SP*CW-1:0] r_R_sp, r_G_sp, r_B_sp;
    logic [CW-1:0]        r_R_bg, r_G_bg, r_B_bg;
    logic [CW-1:0]        w_sel_R, w_sel_G, w_sel_B;

    // Bounds are compared one bit wider so a sprite near the right/bottom edge never wraps.
    for (genvar i = 0; i < NUM_SP; i++) begin : g_sp
        logic [PW:0] w_x0, w_y0;
        logic        w_inside, w_colour;
        assign w_x0     = {1'b0, posX_sp[i*PW +: PW]};
        assign w_y0     = {1'b0, posY_sp[i*PW +: PW]};
        assign w_inside = ({1'b0, pix_x} >= w_x0) && ({1'b0, pix_x} < w_x0 + L_SPW) &&
                          ({1'b0, pix_y} >= w_y0) && ({1'b0, pix_y} < w_y0 + L_SPH);
        assign w_colour = (R_sp[i*CW +: CW] != L_KEY) || (G_sp[i*CW +: CW] != L_KEY) ||
                          (B_sp[i*CW +: CW] != L_KEY);
        assign w_opq[i] = sp_en[i] && w_inside && w_colour;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1   <= 1'b0;
            r_opq  <= '0;
            r_R_sp <= '0;
            r_G_sp <= '0;
            r_B_sp <= '0;
            r_R_bg <= '0;
            r_G_bg <= '0;
            r_B_bg <= '0;
        end else begin
            r_v1   <= pix_valid;
            r_opq  <= w_opq;
            r_R_sp <= R_sp;
            r_G_sp <= G_sp;
            r_B_sp <= B_sp;
            r_R_bg <= R_bg;
            r_G_bg <= G_bg;
            r_B_bg <= B_bg;
        end
    end

    // Walk from highest to lowest index so the lowest opaque sprite lands last and wins.
    always_comb begin
        w_sel_R = r_R_bg;
        w_sel_G = r_G_bg;
        w_sel_B = r_B_bg;
        for (int i = NUM_SP - 1; i >= 0; i--) begin
            if (r_opq[i]) begin
                w_sel_R = r_R_sp[i*CW +: CW];
                w_sel_G = r_G_sp[i*CW +: CW];
                w_sel_B = r_B_sp[i*CW +: CW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            R_out     <= '0;
            G_out     <= '0;
            B_out     <= '0;
        end else begin
            out_valid <= r_v1;
            if (r_v1) begin
                R_out <= w_sel_R;
                G_out <= w_sel_G;
                B_out <= w_sel_B;
            end
        end
    end

`ifdef SPRITE_MERGE_COLL_EN
    logic              w_multi;
    logic [NUM_SP-1:0] r_coll;

    // Clearing the lowest set bit leaves something only when two or more sprites are opaque.
    assign w_multi = |(r_opq & (r_opq - NUM_SP'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_coll <= '0;
        end else begin
            r_coll <= (r_coll & {NUM_SP{~clr_coll}}) | (r_opq & {NUM_SP{r_v1 & w_multi}});
        end
    end

    assign collision = r_coll;
`else
    logic w_unused_clr;
    assign w_unused_clr = clr_coll;
    assign collision    = '0;
`endif

endmodule

// File: tb/tb_sprite_merge_n.sv
// Directed plus randomized bench for sprite_merge_n against a per-pixel reference model.
module tb_sprite_merge_n;

    logic        clk = 1'b0;
    logic        reset, pix_valid, clr_coll;
    logic [9:0]  pix_x, pix_y;
    logic [7:0]  R_bg, G_bg, B_bg;
    logic [31:0] R_sp, G_sp, B_sp;
    logic [39:0] posX_sp, posY_sp;
    logic [3:0]  sp_en;
    logic [7:0]  R_out, G_out, B_out;
    logic        out_valid;
    logic [3:0]  collision;

    sprite_merge_n dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .R_bg(R_bg), .G_bg(G_bg), .B_bg(B_bg), .R_sp(R_sp), .G_sp(G_sp), .B_sp(B_sp),
        .posX_sp(posX_sp), .posY_sp(posY_sp), .sp_en(sp_en), .clr_coll(clr_coll),
        .R_out(R_out), .G_out(G_out), .B_out(B_out), .out_valid(out_valid),
        .collision(collision)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    // Reference model state: the pixel sampled at the previous edge and the expected outputs.
    bit         prev_v = 1'b0;
    int         prev_r = 0, prev_g = 0, prev_b = 0;
    logic [3:0] prev_m = '0;
    bit         exp_v = 1'b0;
    int         exp_r = 0, exp_g = 0, exp_b = 0;
    logic [3:0] exp_coll = '0;

    task automatic set_sprite(input int i, input int x, input int y, input int rgb, input bit en);
        posX_sp[i*10 +: 10] = 10'(x);
        posY_sp[i*10 +: 10] = 10'(y);
        R_sp[i*8 +: 8] = 8'(rgb >> 16);
        G_sp[i*8 +: 8] = 8'(rgb >> 8);
        B_sp[i*8 +: 8] = 8'(rgb);
        sp_en[i] = en;
    endtask

    task automatic eval_pix(output bit v, output int r, output int g, output int b,
                            output logic [3:0] m);
        bit found = 1'b0;
        int px = pix_x;
        int py = pix_y;
        r = R_bg; g = G_bg; b = B_bg; m = '0;
        for (int i = 0; i < 4; i++) begin
            int x0 = posX_sp[i*10 +: 10];
            int y0 = posY_sp[i*10 +: 10];
            int cr = R_sp[i*8 +: 8];
            int cg = G_sp[i*8 +: 8];
            int cb = B_sp[i*8 +: 8];
            if (sp_en[i] && px >= x0 && px < x0 + 16 && py >= y0 && py < y0 + 16 &&
                (cr != 0 || cg != 0 || cb != 0)) begin
                m[i] = 1'b1;
                if (!found) begin
                    r = cr; g = cg; b = cb;
                    found = 1'b1;
                end
            end
        end
        v = pix_valid && !reset;
    endtask

    task automatic tick();
        bit cv;
        int cr, cg, cb;
        logic [3:0] cm;
        eval_pix(cv, cr, cg, cb, cm);
        @(posedge clk);
        if (reset) begin
            exp_v = 0; exp_r = 0; exp_g = 0; exp_b = 0; exp_coll = '0;
        end else begin
            exp_v = prev_v;
            if (prev_v) begin
                exp_r = prev_r; exp_g = prev_g; exp_b = prev_b;
            end
`ifdef SPRITE_MERGE_COLL_EN
            if (clr_coll) exp_coll = '0;
            if (prev_v && $countones(prev_m) >= 2) exp_coll = exp_coll | prev_m;
`endif
        end
        prev_v = cv; prev_r = cr; prev_g = cg; prev_b = cb; prev_m = cm;
        #1;
    endtask

    task automatic check(input string tag);
        ntests++;
        assert (out_valid === exp_v) else begin
            nfail++;
            $error("FAIL %s out_valid got %0b exp %0b", tag, out_valid, exp_v);
        end
        ntests++;
        assert ({R_out, G_out, B_out} === {8'(exp_r), 8'(exp_g), 8'(exp_b)}) else begin
            nfail++;
            $error("FAIL %s rgb got %h exp %h", tag, {R_out, G_out, B_out},
                   {8'(exp_r), 8'(exp_g), 8'(exp_b)});
        end
        ntests++;
        assert (collision === exp_coll) else begin
            nfail++;
            $error("FAIL %s collision got %b exp %b", tag, collision, exp_coll);
        end
    endtask

    task automatic expect_const(input string tag, input logic [31:0] got, input logic [31:0] want);
        ntests++;
        assert (got === want) else begin
            nfail++;
            $error("FAIL %s got %h exp %h", tag, got, want);
        end
    endtask

    task automatic step(input string tag);
        tick();
        check(tag);
    endtask

    logic [3:0] coll_prio;
    int vcnt;

    initial begin
`ifdef SPRITE_MERGE_COLL_EN
        coll_prio = 4'b0011;
`else
        coll_prio = 4'b0000;
`endif
        reset = 1; pix_valid = 1; clr_coll = 0; pix_x = 1; pix_y = 1;
        R_bg = 0; G_bg = 0; B_bg = 0;
        R_sp = '0; G_sp = '0; B_sp = '0; posX_sp = '0; posY_sp = '0; sp_en = '0;
        for (int i = 0; i < 4; i++) set_sprite(i, 600, 500, 32'h112233, 1'b1);

        for (int n = 0; n < 5; n++) begin
            step("reset");
            expect_const("reset_out", {7'd0, out_valid, R_out, G_out, B_out}, 32'h0);
        end

        // Background only
        reset = 0; R_bg = 8'h20; G_bg = 8'h50; B_bg = 8'h40;
        step("bg_in");
        pix_valid = 0;
        step("bg_out");
        expect_const("bg_rgb", {7'd0, out_valid, R_out, G_out, B_out}, 32'h01205040);
        step("bg_hold");
        expect_const("bg_hold_rgb", {8'd0, R_out, G_out, B_out}, 32'h205040);

        // Priority between two overlapping sprites
        set_sprite(0, 0, 0, 32'h305441, 1'b1);
        set_sprite(1, 0, 0, 32'h171717, 1'b1);
        pix_x = 5; pix_y = 5; pix_valid = 1;
        step("prio_in");
        pix_valid = 0;
        step("prio_out");
        expect_const("prio_rgb", {8'd0, R_out, G_out, B_out}, 32'h305441);
        expect_const("prio_coll", {28'd0, collision}, {28'd0, coll_prio});

        // Sticky hold over clean pixels, then clear
        pix_x = 100; pix_y = 100; pix_valid = 1;
        for (int n = 0; n < 10; n++) step("sticky");
        expect_const("sticky_coll", {28'd0, collision}, {28'd0, coll_prio});
        pix_valid = 0; clr_coll = 1;
        step("clr1");
        expect_const("clr1_coll", {28'd0, collision}, 32'h0);
        clr_coll = 0; pix_x = 5; pix_y = 5; pix_valid = 1;
        step("setclr_in");
        pix_valid = 0; clr_coll = 1;
        step("setclr_same");
        expect_const("setwins_coll", {28'd0, collision}, {28'd0, coll_prio});
        step("clr_alone");
        expect_const("clr_alone_coll", {28'd0, collision}, 32'h0);
        clr_coll = 0;

        // Key colour and right-edge bounds
        set_sprite(1, 600, 500, 32'h171717, 1'b1);
        set_sprite(0, 0, 0, 32'h000000, 1'b1);
        pix_valid = 1;
        step("key_in");
        pix_valid = 0;
        step("key_out");
        expect_const("key_rgb", {8'd0, R_out, G_out, B_out}, 32'h205040);
        set_sprite(0, 1010, 0, 32'hAABBCC, 1'b1);
        pix_x = 1023; pix_valid = 1;
        step("edge_in");
        pix_x = 1009;
        step("edge_in2");
        expect_const("edge_rgb", {8'd0, R_out, G_out, B_out}, 32'hAABBCC);
        pix_valid = 0;
        step("edge_out2");
        expect_const("edge_out_bg", {8'd0, R_out, G_out, B_out}, 32'h205040);

        // Mid-stream reset discards the in-flight pixel
        pix_x = 1020; pix_valid = 1;
        step("mid_in");
        reset = 1;
        step("mid_rst");
        reset = 0; pix_valid = 0;
        step("mid_drain");
        expect_const("mid_discard", {7'd0, out_valid, R_out, G_out, B_out}, 32'h0);
        pix_valid = 1;
        step("mid_new");
        pix_valid = 0;
        step("mid_new_out");
        expect_const("mid_new_rgb", {7'd0, out_valid, R_out, G_out, B_out}, 32'h01AABBCC);
        step("gap");

        // Randomized streaming against the model
        vcnt = 0;
        for (int n = 0; n < 102; n++) begin
            if (n < 100) begin
                int base;
                base = $urandom_range(0, 1023);
                for (int i = 0; i < 4; i++)
                    set_sprite(i, base + $urandom_range(0, 12), $urandom_range(0, 8),
                               ($urandom_range(0, 3) == 0) ? 0 : int'($urandom),
                               $urandom_range(0, 3) != 0);
                R_bg = 8'($urandom); G_bg = 8'($urandom); B_bg = 8'($urandom);
                pix_x = 10'(base + $urandom_range(0, 30));
                pix_y = 10'($urandom_range(0, 24));
                clr_coll = ($urandom_range(0, 15) == 0);
                pix_valid = 1;
            end else begin
                pix_valid = 0;
                clr_coll = 0;
            end
            step("stream");
            if (out_valid) vcnt++;
        end
        expect_const("stream_count", 32'(vcnt), 32'd100);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
